// File: rtl/jtframe_sdram_pkg.sv
// Shared definitions for the SDRAM arbiters.
//   MODE_*      : priority-mode selectors for the MODE parameter
//   LFSR_*      : 15-bit Fibonacci LFSR seed and feedback taps
//   rotsearch() : first requesting index at or after a start index, wrapping modulo n
package jtframe_sdram_pkg;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;
  localparam int unsigned MODE_LFSR  = 2;

  localparam logic [14:0] LFSR_SEED  = 15'd1;
  localparam int unsigned LFSR_TAP_A = 0;
  localparam int unsigned LFSR_TAP_B = 14;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } search_t;

  // start must be below n; the wrap is a single subtraction so indices
  // n..7 are never visited, which keeps non-power-of-two counts correct.
  function automatic search_t rotsearch(input logic [7:0] req,
                                        input logic [2:0] start,
                                        input int unsigned n);
    search_t     r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      j = 32'(start) + k;
      if (j >= n) j = j - n;
      if (k < n && !r.found && req[j[2:0]]) begin
        r.found = 1'b1;
        r.idx   = j[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/jtframe_sdram_arb_if.sv
// Request/grant bundle between the bank controllers and the arbiter.
//   master : requester side (drives hold, br, idle, rfsh_br)
//   slave  : arbiter side   (drives bg, gidx, rfsh_bg, starved)
interface jtframe_sdram_arb_if #(
  parameter int unsigned NCH = 4
);
  logic           hold;
  logic [NCH-1:0] br;
  logic           idle;
  logic           rfsh_br;
  logic [NCH-1:0] bg;
  logic [2:0]     gidx;
  logic           rfsh_bg;
  logic [NCH-1:0] starved;

  modport master (output hold, br, idle, rfsh_br,
                  input  bg, gidx, rfsh_bg, starved);
  modport slave  (input  hold, br, idle, rfsh_br,
                  output bg, gidx, rfsh_bg, starved);
endinterface

// File: rtl/jtframe_sdram_arb_lfsr.sv
// 15-bit Fibonacci LFSR, period 32767, never reaches zero from the seed.
//   clk, rst_n : clock, async active-low reset (loads LFSR_SEED)
//   i_en       : step enable
//   o_rnd      : low OW bits of the state
module jtframe_sdram_arb_lfsr
  import jtframe_sdram_pkg::*;
#(
  parameter int unsigned OW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  output logic [OW-1:0] o_rnd
);
  logic [14:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_state <= LFSR_SEED;
    else if (i_en) r_state <= {r_state[LFSR_TAP_A] ^ r_state[LFSR_TAP_B], r_state[14:1]};
  end

  assign o_rnd = r_state[OW-1:0];
endmodule

// File: rtl/jtframe_sdram_arb.sv
// N-channel SDRAM bus arbiter with fixed / round-robin / LFSR priority,
// per-channel starvation forcing and refresh grant.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of jtframe_sdram_arb_if
//                in : hold, br[NCH], idle, rfsh_br
//                out: bg[NCH] one-hot, gidx, rfsh_bg, starved[NCH]
// Grants are combinational from registered state and inputs (zero latency).
module jtframe_sdram_arb
  import jtframe_sdram_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned MODE   = MODE_RR,
  parameter int unsigned STARVE = 7,
  parameter int unsigned CW     = 8
) (
  input logic                clk,
  input logic                rst_n,
  jtframe_sdram_arb_if.slave bus
);
  logic [2:0]     r_ptr;
  logic [CW-1:0]  r_cnt [NCH];
  logic [2:0]     w_rnd;
  logic           w_ge;
  logic [NCH-1:0] w_starved;
  logic [NCH-1:0] w_bg;
  logic [2:0]     w_gidx;
  logic [2:0]     w_start;
  logic [7:0]     w_req;
  logic [7:0]     w_force;
  logic           w_grant;
  search_t        w_fs;
  search_t        w_ms;

  jtframe_sdram_arb_lfsr #(.OW(3)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (1'b1),
    .o_rnd (w_rnd)
  );

  assign w_ge = rst_n & ~bus.hold;

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++)
      w_starved[i] = (r_cnt[i] == CW'(STARVE));
  end

  always_comb begin
    w_req            = '0;
    w_req[NCH-1:0]   = bus.br;
    w_force          = '0;
    w_force[NCH-1:0] = bus.br & w_starved;
    case (MODE)
      MODE_FIXED: w_start = '0;
      MODE_RR:    w_start = r_ptr;
      default:    w_start = 3'(32'(w_rnd) % NCH);
    endcase
    // Starved requesters always pre-empt the mode search, lowest index first.
    w_fs    = rotsearch(w_force, 3'd0, NCH);
    w_ms    = rotsearch(w_req, w_start, NCH);
    w_grant = w_ge & w_ms.found;
    w_gidx  = '0;
    if (w_grant) w_gidx = w_fs.found ? w_fs.idx : w_ms.idx;
    w_bg    = w_grant ? (NCH'(1) << w_gidx) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      for (int unsigned i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else if (w_ge) begin
      if (w_grant) r_ptr <= (w_gidx == 3'(NCH - 1)) ? 3'd0 : w_gidx + 3'd1;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!bus.br[i] || w_bg[i])          r_cnt[i] <= '0;
        else if (r_cnt[i] != CW'(STARVE))   r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

  assign bus.bg      = w_bg;
  assign bus.gidx    = w_gidx;
  assign bus.starved = w_starved;
  assign bus.rfsh_bg = w_ge & bus.rfsh_br & bus.idle & ~|bus.br;

  a_onehot_bg: assert property (@(posedge clk) $onehot0(w_bg));

endmodule
